// File: rtl/if_fetch_queue.sv
// if_fetch_queue: PC generation plus in-order prefetch queue between imem and ID
// clk, rst        clock (rising edge), asynchronous active-high reset
// branch_ctrl     00/11 sequential, 01 redirect to pc_imm, 10 redirect to pc_immrs1
// imem_req_*      fetch request channel (valid/ready), addr is the current PC
// imem_rsp_*      fetch responses, returned in request order
// id_*            queue head towards decode (valid/ready, pc, instr)
// rsp_err         sticky flag: response arrived with nothing outstanding
module if_fetch_queue #(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter int FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [ILEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      branch_ctrl,
  input  logic [XLEN-1:0] pc_imm,
  input  logic [XLEN-1:0] pc_immrs1,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [ILEN-1:0] id_instr,
  output logic            rsp_err
);
  localparam int AW = $clog2(FQ_DEPTH);
  localparam int CW = AW + 1;
  // stale requests from repeated redirects can push outstanding beyond the queue depth
  localparam int OW = AW + 3;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] qpc_q [FQ_DEPTH];
  logic [ILEN-1:0] qins_q [FQ_DEPTH];
  logic [XLEN-1:0] ppc_q [FQ_DEPTH];
  logic [AW-1:0] qwr_q, qrd_q, pwr_q, prd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] out_q, out_d, drop_q, drop_d;
  logic [OW:0] inflight;
  logic err_q;
  logic redirect, accept, rsp_ok, drop, push, pop;
  logic [XLEN-1:0] target;
  always_comb begin
    redirect = branch_ctrl == 2'b01 || branch_ctrl == 2'b10;
    target = branch_ctrl == 2'b01 ? pc_imm : pc_immrs1;
    inflight = (OW+1)'(cnt_q) + (OW+1)'(out_q) - (OW+1)'(drop_q);
    imem_req_valid = !rst && !redirect && inflight < (OW+1)'(FQ_DEPTH);
    accept = imem_req_valid && imem_req_ready;
    rsp_ok = imem_rsp_valid && out_q != '0;
    drop = rsp_ok && drop_q != '0;
    push = rsp_ok && !drop && !redirect;
    id_valid = cnt_q != '0;
    pop = id_valid && id_ready && !redirect;
    pc_d = redirect ? target : accept ? pc_q + XLEN'(4) : pc_q;
    out_d = out_q + OW'(accept) - OW'(rsp_ok);
    drop_d = redirect ? out_q - OW'(rsp_ok) : drop_q - OW'(drop);
    cnt_d = redirect ? '0 : cnt_q + CW'(push) - CW'(pop);
    imem_req_addr = pc_q;
    id_pc = id_valid ? qpc_q[qrd_q] : '0;
    id_instr = id_valid ? qins_q[qrd_q] : NOP_INSTR;
    rsp_err = err_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
      cnt_q <= '0;
      out_q <= '0;
      drop_q <= '0;
      err_q <= 1'b0;
      qwr_q <= '0;
      qrd_q <= '0;
      pwr_q <= '0;
      prd_q <= '0;
    end else begin
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      drop_q <= drop_d;
      err_q <= err_q || (imem_rsp_valid && !rsp_ok);
      qwr_q <= redirect ? '0 : qwr_q + AW'(push);
      qrd_q <= redirect ? '0 : qrd_q + AW'(pop);
      pwr_q <= redirect ? '0 : pwr_q + AW'(accept);
      prd_q <= redirect ? '0 : prd_q + AW'(push);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      qpc_q[qwr_q] <= ppc_q[prd_q];
      qins_q[qwr_q] <= imem_rsp_data;
    end
    if (accept) ppc_q[pwr_q] <= pc_q;
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: scoreboard bench for the fetch stage with an in-order imem model
module tb_if_fetch_queue;
  localparam logic [31:0] NOP = 32'h00000013;
  typedef struct {
    logic [31:0] addr;
    int due;
    bit stale;
  } req_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] branch_ctrl = 2'b00;
  logic [31:0] pc_imm = '0, pc_immrs1 = '0;
  logic imem_req_valid;
  logic imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic id_valid;
  logic id_ready = 1'b0;
  logic [31:0] id_pc, id_instr;
  logic rsp_err;
  req_t imem_q[$];
  logic [31:0] exp_q[$];
  int n_tests = 0, n_fail = 0, cyc = 0, n_pop = 0, n_acc = 0;
  int rdy_pct = 100, idr_pct = 100, lat_lo = 1, lat_hi = 1;
  logic [1:0] bc = 2'b00;
  logic [31:0] tgt = '0;
  bit spur = 1'b0;
  logic [31:0] exp_pc = '0, last_pop_pc = '0, prev_addr = '0;
  bit prev_hold = 1'b0;
  logic s_req_valid, s_id_valid, s_acc, s_rsp_err;
  logic [31:0] s_req_addr, s_id_pc;
  always #5 clk = ~clk;
  if_fetch_queue dut (
    .clk(clk), .rst(rst), .branch_ctrl(branch_ctrl), .pc_imm(pc_imm), .pc_immrs1(pc_immrs1),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr), .rsp_err(rsp_err)
  );
  function automatic logic [31:0] ifn(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h00C0FFEE;
  endfunction
  task automatic step();
    bit redir, rsp_now;
    req_t r;
    logic [31:0] e;
    @(negedge clk);
    redir = bc == 2'b01 || bc == 2'b10;
    branch_ctrl = bc;
    pc_imm = bc == 2'b01 ? tgt : 32'hBAD0_0000;
    pc_immrs1 = bc == 2'b10 ? tgt : 32'hBAD1_0000;
    imem_req_ready = $urandom_range(99) < rdy_pct;
    id_ready = $urandom_range(99) < idr_pct;
    rsp_now = imem_q.size() != 0 && imem_q[0].due <= cyc;
    imem_rsp_valid = rsp_now || (spur && imem_q.size() == 0);
    imem_rsp_data = rsp_now ? ifn(imem_q[0].addr) : 32'hDEADBEEF;
    #1;
    s_req_valid = imem_req_valid;
    s_req_addr = imem_req_addr;
    s_id_valid = id_valid;
    s_id_pc = id_pc;
    s_rsp_err = rsp_err;
    s_acc = imem_req_valid && imem_req_ready;
    if (id_valid && id_ready && !redir) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL id_extra: got pc=%h instr=%h, required no entry", id_pc, id_instr);
      end else begin
        e = exp_q.pop_front();
        if (id_pc !== e || id_instr !== ifn(e)) begin
          n_fail++;
          $display("FAIL id_order: got pc=%h instr=%h, required pc=%h instr=%h", id_pc, id_instr, e, ifn(e));
        end
      end
      last_pop_pc = id_pc;
      n_pop++;
    end
    if (!id_valid) begin
      n_tests++;
      if (id_pc !== 32'h0 || id_instr !== NOP) begin
        n_fail++;
        $display("FAIL idle_out: got pc=%h instr=%h, required pc=0 instr=%h", id_pc, id_instr, NOP);
      end
    end
    if (redir) begin
      n_tests++;
      if (imem_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL req_in_redirect: got req_valid=%b, required 0", imem_req_valid);
      end
    end
    if (prev_hold && !redir) begin
      n_tests++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
        n_fail++;
        $display("FAIL req_hold: got valid=%b addr=%h, required valid=1 addr=%h", imem_req_valid, imem_req_addr, prev_addr);
      end
    end
    if (redir) exp_q.delete();
    if (rsp_now) begin
      r = imem_q.pop_front();
      if (!r.stale && !redir) exp_q.push_back(r.addr);
    end
    if (redir) foreach (imem_q[i]) imem_q[i].stale = 1'b1;
    if (s_acc) begin
      n_tests++;
      if (imem_req_addr !== exp_pc) begin
        n_fail++;
        $display("FAIL req_addr: got %h, required %h", imem_req_addr, exp_pc);
      end
      r.addr = imem_req_addr;
      r.due = cyc + int'($urandom_range(lat_hi, lat_lo));
      r.stale = 1'b0;
      imem_q.push_back(r);
      exp_pc += 32'd4;
      n_acc++;
    end
    if (redir) exp_pc = tgt;
    prev_hold = imem_req_valid && !imem_req_ready;
    prev_addr = imem_req_addr;
    cyc++;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bc = 2'b00;
    branch_ctrl = 2'b00;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    id_ready = 1'b0;
    spur = 1'b0;
    imem_q.delete();
    exp_q.delete();
    exp_pc = '0;
    prev_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_tests++;
    if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_id_valid: got %b, required 0", id_valid); end
    n_tests++;
    if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b, required 0", imem_req_valid); end
    n_tests++;
    if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL rst_req_addr: got %h, required 0", imem_req_addr); end
    n_tests++;
    if (id_pc !== 32'h0 || id_instr !== NOP) begin n_fail++; $display("FAIL rst_id_out: got pc=%h instr=%h, required 0/%h", id_pc, id_instr, NOP); end
    n_tests++;
    if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err: got %b, required 0", rsp_err); end
  endtask
  task automatic test_back_to_back();
    int first_acc, first_v, p0;
    do_reset();
    rdy_pct = 100; idr_pct = 100; lat_lo = 1; lat_hi = 1;
    first_acc = -1; first_v = -1; p0 = n_pop;
    repeat (20) begin
      step();
      if (s_acc && first_acc < 0) first_acc = cyc - 1;
      if (s_id_valid && first_v < 0) first_v = cyc - 1;
    end
    n_tests++;
    if (first_acc < 0 || first_v - first_acc != 2) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles, required 2", first_v - first_acc);
    end
    n_tests++;
    if (n_pop - p0 != 18) begin n_fail++; $display("FAIL throughput: got %0d pops, required 18", n_pop - p0); end
  endtask
  task automatic test_stall();
    int a0;
    do_reset();
    rdy_pct = 100; idr_pct = 0; lat_lo = 1; lat_hi = 1;
    a0 = n_acc;
    repeat (12) step();
    n_tests++;
    if (n_acc - a0 != 4) begin n_fail++; $display("FAIL stall_accepts: got %0d, required 4", n_acc - a0); end
    n_tests++;
    if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_req_valid: got %b, required 0", s_req_valid); end
    n_tests++;
    if (s_id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_id_valid: got %b, required 1", s_id_valid); end
    idr_pct = 100;
    step();
    n_tests++;
    if (s_id_valid !== 1'b1 || s_id_pc !== 32'h0) begin n_fail++; $display("FAIL stall_release: got valid=%b pc=%h, required 1/0", s_id_valid, s_id_pc); end
    repeat (10) step();
  endtask
  task automatic test_redirect_drop();
    int p0, k;
    do_reset();
    rdy_pct = 100; idr_pct = 100; lat_lo = 4; lat_hi = 4;
    repeat (3) step();
    bc = 2'b01; tgt = 32'h100;
    step();
    bc = 2'b00;
    step();
    n_tests++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h100) begin n_fail++; $display("FAIL redir01_addr: got valid=%b addr=%h, required 1/100", s_req_valid, s_req_addr); end
    p0 = n_pop; k = 0;
    while (n_pop == p0 && k < 20) begin step(); k++; end
    n_tests++;
    if (n_pop == p0 || last_pop_pc !== 32'h100) begin n_fail++; $display("FAIL redir01_first: got pc=%h, required 100", last_pop_pc); end
    repeat (8) step();
  endtask
  task automatic test_redirect_rsp();
    int p0, k;
    do_reset();
    rdy_pct = 100; idr_pct = 100; lat_lo = 2; lat_hi = 2;
    repeat (6) step();
    bc = 2'b10; tgt = 32'h200;
    step();
    bc = 2'b00;
    n_tests++;
    if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir10_req: got %b, required 0", s_req_valid); end
    step();
    n_tests++;
    if (s_id_valid !== 1'b0) begin n_fail++; $display("FAIL redir10_id_valid: got %b, required 0", s_id_valid); end
    n_tests++;
    if (s_req_addr !== 32'h200) begin n_fail++; $display("FAIL redir10_addr: got %h, required 200", s_req_addr); end
    p0 = n_pop; k = 0;
    while (n_pop == p0 && k < 20) begin step(); k++; end
    n_tests++;
    if (n_pop == p0 || last_pop_pc !== 32'h200) begin n_fail++; $display("FAIL redir10_first: got pc=%h, required 200", last_pop_pc); end
    lat_lo = 1; lat_hi = 1;
  endtask
  task automatic test_random();
    int p0;
    do_reset();
    rdy_pct = 50; idr_pct = 80; lat_lo = 1; lat_hi = 5;
    p0 = n_pop;
    repeat (400) step();
    n_tests++;
    if (n_pop - p0 < 100) begin n_fail++; $display("FAIL random_pops: got %0d, required at least 100", n_pop - p0); end
    n_tests++;
    if (s_rsp_err !== 1'b0) begin n_fail++; $display("FAIL random_rsp_err: got %b, required 0", s_rsp_err); end
  endtask
  task automatic test_spurious_and_reset();
    int k, p0;
    logic v0;
    logic [31:0] pc0;
    rdy_pct = 0; idr_pct = 0;
    k = 0;
    while (imem_q.size() != 0 && k < 50) begin step(); k++; end
    n_tests++;
    if (imem_q.size() != 0) begin n_fail++; $display("FAIL drain_timeout: got %0d outstanding, required 0", imem_q.size()); end
    v0 = s_id_valid; pc0 = s_id_pc;
    spur = 1'b1;
    step();
    spur = 1'b0;
    step();
    n_tests++;
    if (s_rsp_err !== 1'b1) begin n_fail++; $display("FAIL spur_rsp_err: got %b, required 1", s_rsp_err); end
    n_tests++;
    if (s_id_valid !== v0 || s_id_pc !== pc0) begin n_fail++; $display("FAIL spur_queue: got valid=%b pc=%h, required %b/%h", s_id_valid, s_id_pc, v0, pc0); end
    idr_pct = 100;
    repeat (10) step();
    n_tests++;
    if (s_id_valid !== 1'b0) begin n_fail++; $display("FAIL spur_drain: got id_valid=%b, required 0", s_id_valid); end
    rdy_pct = 100; lat_lo = 3; lat_hi = 3;
    repeat (6) step();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got id=%b req=%b, required 0/0", id_valid, imem_req_valid); end
    n_tests++;
    if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_addr: got %h, required 0", imem_req_addr); end
    n_tests++;
    if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp_err: got %b, required 0", rsp_err); end
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    id_ready = 1'b0;
    imem_q.delete();
    exp_q.delete();
    exp_pc = '0;
    prev_hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    p0 = n_pop;
    repeat (12) step();
    n_tests++;
    if (n_pop - p0 < 5) begin n_fail++; $display("FAIL midrst_restart: got %0d pops, required at least 5", n_pop - p0); end
  endtask
  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_redirect_drop();
    test_redirect_rsp();
    test_random();
    test_spurious_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
